// File: rtl/qam_symbol_pacer_if.sv
// Streamer-side and mapper-side signals of the QAM symbol pacer.
// The master drives writes and register settings; the slave returns paced symbols and status.
interface qam_symbol_pacer_if #(
  parameter int DEPTH    = 16,
  parameter int SYMBOL_W = 4,
  parameter int PERIOD_W = 16
);
  localparam int LEVEL_W = $clog2(DEPTH) + 1;

  logic [SYMBOL_W-1:0] qam_block;
  logic                qam_block_valid;
  logic                enable;
  logic [PERIOD_W-1:0] symbol_period;
  logic                clear_flags;
  logic [SYMBOL_W-1:0] out_block;
  logic                out_valid;
  logic [LEVEL_W-1:0]  level;
  logic                full;
  logic                overflow;
  logic                underflow;

  modport master (
    output qam_block, qam_block_valid, enable, symbol_period, clear_flags,
    input  out_block, out_valid, level, full, overflow, underflow
  );

  modport slave (
    input  qam_block, qam_block_valid, enable, symbol_period, clear_flags,
    output out_block, out_valid, level, full, overflow, underflow
  );
endinterface

// File: rtl/qam_symbol_pacer.sv
// Elastic FIFO plus symbol-rate timer: buffers bursty QAM blocks and releases
// one every programmable period, with fill level and sticky over/underflow flags.
module qam_symbol_pacer #(
  parameter int DEPTH    = 16,
  parameter int SYMBOL_W = 4,
  parameter int PERIOD_W = 16
) (
  input logic               clk,
  input logic               rst_n,
  qam_symbol_pacer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, RUN = 2'd2} state_t;

  state_t              state_r, state_s;
  logic [SYMBOL_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]       wr_ptr_r, rd_ptr_r;
  logic [LW-1:0]       level_r, level_s;
  logic [PERIOD_W-1:0] cnt_r, cnt_s, reload_s;
  logic [SYMBOL_W-1:0] out_block_r;
  logic                out_valid_r, full_r, overflow_r, underflow_r;
  logic                rd_s, wr_s, ovf_set_s, udf_set_s, empty_s;

  // Next state, period counter, read decision and FIFO bookkeeping.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    rd_s      = 1'b0;
    udf_set_s = 1'b0;
    empty_s   = (level_r == {LW{1'b0}});
    // A zero period behaves as one clock, i.e. reload value zero.
    if (bus.symbol_period == {PERIOD_W{1'b0}}) begin
      reload_s = {PERIOD_W{1'b0}};
    end else begin
      reload_s = bus.symbol_period - PERIOD_W'(1);
    end
    case (state_r)
      IDLE: begin
        if (bus.enable) begin
          state_s = PRIME;
        end else begin
          state_s = IDLE;
        end
      end
      PRIME: begin
        if (!bus.enable) begin
          state_s = IDLE;
        end else if (level_r >= LW'(DEPTH / 2)) begin
          state_s = RUN;
          cnt_s   = reload_s;
        end else begin
          state_s = PRIME;
        end
      end
      RUN: begin
        if (!bus.enable) begin
          state_s = IDLE;
        end else if (cnt_r == {PERIOD_W{1'b0}}) begin
          cnt_s = reload_s;
          if (!empty_s) begin
            rd_s = 1'b1;
          end else begin
            udf_set_s = 1'b1;
            state_s   = PRIME;
          end
        end else begin
          cnt_s = cnt_r - PERIOD_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    // A full FIFO still accepts a write when the same cycle pops the head.
    wr_s      = bus.qam_block_valid && (!full_r || rd_s);
    ovf_set_s = bus.qam_block_valid && full_r && !rd_s;
    case ({wr_s, rd_s})
      2'b10:   level_s = level_r + LW'(1);
      2'b01:   level_s = level_r - LW'(1);
      default: level_s = level_r;
    endcase
  end

  // State, pointers, level, counter, output register and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= {PERIOD_W{1'b0}};
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      level_r     <= {LW{1'b0}};
      full_r      <= 1'b0;
      out_block_r <= {SYMBOL_W{1'b0}};
      out_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      level_r     <= level_s;
      full_r      <= (level_s == LW'(DEPTH));
      out_valid_r <= rd_s;
      if (wr_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (rd_s) begin
        rd_ptr_r    <= rd_ptr_r + AW'(1);
        out_block_r <= mem_r[rd_ptr_r];
      end
      // Setting beats clearing when both happen in the same cycle.
      overflow_r  <= ovf_set_s | (overflow_r & ~bus.clear_flags);
      underflow_r <= udf_set_s | (underflow_r & ~bus.clear_flags);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[wr_ptr_r] <= bus.qam_block;
    end
  end

  assign bus.out_block = out_block_r;
  assign bus.out_valid = out_valid_r;
  assign bus.level     = level_r;
  assign bus.full      = full_r;
  assign bus.overflow  = overflow_r;
  assign bus.underflow = underflow_r;
endmodule

// File: tb/tb_qam_symbol_pacer.sv
// Randomized bench for qam_symbol_pacer: queue/absolute-time reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_qam_symbol_pacer;
  localparam int DEPTH    = 16;
  localparam int SYMBOL_W = 4;
  localparam int PERIOD_W = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  qam_symbol_pacer_if #(.DEPTH(DEPTH), .SYMBOL_W(SYMBOL_W), .PERIOD_W(PERIOD_W)) pif ();

  qam_symbol_pacer #(.DEPTH(DEPTH), .SYMBOL_W(SYMBOL_W), .PERIOD_W(PERIOD_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (pif)
  );

  int checks = 0;
  int errors = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of symbols, a phase and the absolute edge number of the next tick.
  logic [SYMBOL_W-1:0] mq[$];
  int                  m_phase = 0;  // 0 idle, 1 priming, 2 running
  longint              m_n     = 0;
  longint              m_next  = 0;
  logic [SYMBOL_W-1:0] m_block = '0;
  bit                  m_valid = 1'b0;
  bit                  m_of    = 1'b0;
  bit                  m_uf    = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    int p;
    bit rd, ofs, ufs;
    logic [SYMBOL_W-1:0] head;
    if (!rst_n) begin
      mq.delete();
      m_phase = 0; m_n = 0; m_next = 0;
      m_block = '0; m_valid = 1'b0; m_of = 1'b0; m_uf = 1'b0;
    end else begin
      p    = (pif.symbol_period == 0) ? 1 : int'(pif.symbol_period);
      rd   = 1'b0; ofs = 1'b0; ufs = 1'b0; head = '0;
      if (m_phase == 0) begin
        if (pif.enable) m_phase = 1;
      end else if (m_phase == 1) begin
        if (!pif.enable) m_phase = 0;
        else if (mq.size() >= DEPTH / 2) begin
          m_phase = 2;
          m_next  = m_n + p;
        end
      end else begin
        if (!pif.enable) m_phase = 0;
        else if (m_n == m_next) begin
          m_next = m_n + p;
          if (mq.size() > 0) begin
            rd   = 1'b1;
            head = mq.pop_front();
          end else begin
            ufs     = 1'b1;
            m_phase = 1;
          end
        end
      end
      if (pif.qam_block_valid) begin
        if (mq.size() < DEPTH) mq.push_back(pif.qam_block);
        else ofs = 1'b1;
      end
      m_valid = rd;
      if (rd) m_block = head;
      m_of = ofs | (m_of & !pif.clear_flags);
      m_uf = ufs | (m_uf & !pif.clear_flags);
      m_n++;
    end
  end

  // Per-cycle comparison against the model, plus a log of strobe times and values.
  int                  cyc = 0;
  int                  st_t[$];
  logic [SYMBOL_W-1:0] st_v[$];
  bit                  seen_f = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (pif.out_valid) begin
        st_t.push_back(cyc);
        st_v.push_back(pif.out_block);
        if (pif.out_block == 4'hF) seen_f = 1'b1;
      end
      cmp("valid", 32'(pif.out_valid), 32'(m_valid));
      cmp("block", 32'(pif.out_block), 32'(m_block));
      cmp("level", 32'(pif.level), 32'(mq.size()));
      cmp("full", 32'(pif.full), 32'(mq.size() == DEPTH));
      cmp("overflow", 32'(pif.overflow), 32'(m_of));
      cmp("underflow", 32'(pif.underflow), 32'(m_uf));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic write_n(input int n, input bit ramp);
    for (int i = 0; i < n; i++) begin
      pif.qam_block_valid = 1'b1;
      pif.qam_block       = ramp ? SYMBOL_W'(i + 1) : SYMBOL_W'($urandom_range(0, 14));
      step(1);
    end
    pif.qam_block_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    pif.clear_flags = 1'b1;
    step(1);
    pif.clear_flags = 1'b0;
  endtask

  task automatic clear_log();
    st_t.delete();
    st_v.delete();
  endtask

  initial begin : stim
    int n0;
    int k;
    pif.qam_block       = '0;
    pif.qam_block_valid = 1'b0;
    pif.enable          = 1'b0;
    pif.symbol_period   = 16'd10;
    pif.clear_flags     = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(2);
    cmp("rst_level", 32'(pif.level), 32'd0);
    cmp("rst_full", 32'(pif.full), 32'd0);
    cmp("rst_valid", 32'(pif.out_valid), 32'd0);
    cmp("rst_block", 32'(pif.out_block), 32'd0);
    cmp("rst_of", 32'(pif.overflow), 32'd0);
    cmp("rst_uf", 32'(pif.underflow), 32'd0);

    // Eight ramp symbols at period 10, then drain into underflow.
    clear_log();
    pif.enable = 1'b1;
    write_n(8, 1'b1);
    step(120);
    cmp("t2_count", 32'(st_v.size()), 32'd8);
    for (int i = 0; i < st_v.size() && i < 8; i++) cmp("t2_val", 32'(st_v[i]), 32'(i + 1));
    for (int i = 1; i < st_t.size(); i++) cmp("t2_gap", 32'(st_t[i] - st_t[i-1]), 32'd10);
    cmp("t2_uf", 32'(pif.underflow), 32'd1);
    cmp("t2_level", 32'(pif.level), 32'd0);
    pif.enable = 1'b0;
    pulse_clear();

    // Seventeen writes while idle: the last one is dropped.
    for (int i = 0; i < 17; i++) begin
      pif.qam_block_valid = 1'b1;
      pif.qam_block       = (i == 16) ? 4'hF : SYMBOL_W'($urandom_range(0, 14));
      step(1);
      if (i == 15) cmp("t3_full16", 32'(pif.full), 32'd1);
    end
    pif.qam_block_valid = 1'b0;
    step(1);
    cmp("t3_level", 32'(pif.level), 32'd16);
    cmp("t3_full", 32'(pif.full), 32'd1);
    cmp("t3_of", 32'(pif.overflow), 32'd1);
    pulse_clear();

    // Full FIFO at P=1 with a write every clock: level holds, strobe every clock.
    pif.symbol_period = 16'd1;
    pif.enable        = 1'b1;
    step(2);
    n0 = st_t.size();
    write_n(40, 1'b0);
    cmp("t4_strobes", 32'(st_t.size() - n0), 32'd40);
    cmp("t4_level", 32'(pif.level), 32'd16);
    cmp("t4_of", 32'(pif.overflow), 32'd0);
    step(25);
    pif.enable = 1'b0;
    pulse_clear();

    // Period change 10 -> 4 in the middle of a period.
    pif.symbol_period = 16'd10;
    write_n(8, 1'b0);
    clear_log();
    pif.enable = 1'b1;
    k = 0;
    while (st_t.size() < 1 && k < 40) begin
      step(1);
      k++;
    end
    cmp("t5_wait", 32'(st_t.size() >= 1), 32'd1);
    step(3);
    pif.symbol_period = 16'd4;
    step(60);
    cmp("t5_count", 32'(st_t.size()), 32'd8);
    for (int i = 1; i < st_t.size(); i++)
      cmp("t5_gap", 32'(st_t[i] - st_t[i-1]), (i == 1) ? 32'd10 : 32'd4);
    // Zero period behaves as one clock.
    pif.symbol_period = 16'd0;
    clear_log();
    write_n(8, 1'b0);
    step(20);
    cmp("t5_p0_count", 32'(st_t.size()), 32'd8);
    for (int i = 1; i < st_t.size(); i++) cmp("t5_p0_gap", 32'(st_t[i] - st_t[i-1]), 32'd1);
    pif.enable = 1'b0;
    pulse_clear();

    // Underflow while clear is held: set must win.
    pif.symbol_period = 16'd2;
    write_n(8, 1'b0);
    pif.clear_flags = 1'b1;
    pif.enable      = 1'b1;
    k = 0;
    while (pif.underflow !== 1'b1 && k < 60) begin
      step(1);
      k++;
    end
    cmp("t6_set_wins", 32'(pif.underflow), 32'd1);
    pif.clear_flags = 1'b0;
    step(1);
    cmp("t6_hold", 32'(pif.underflow), 32'd1);
    pulse_clear();
    cmp("t6_cleared", 32'(pif.underflow), 32'd0);
    pif.enable = 1'b0;
    step(1);

    // Asynchronous reset mid-RUN with five entries buffered.
    pif.symbol_period = 16'd10;
    write_n(8, 1'b0);
    clear_log();
    pif.enable = 1'b1;
    k = 0;
    while (st_t.size() < 3 && k < 100) begin
      step(1);
      k++;
    end
    cmp("t1_wait", 32'(st_t.size()), 32'd3);
    step(2);
    cmp("t1_level5", 32'(pif.level), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    cmp("t1_level", 32'(pif.level), 32'd0);
    cmp("t1_full", 32'(pif.full), 32'd0);
    cmp("t1_valid", 32'(pif.out_valid), 32'd0);
    cmp("t1_block", 32'(pif.out_block), 32'd0);
    cmp("t1_of", 32'(pif.overflow), 32'd0);
    cmp("t1_uf", 32'(pif.underflow), 32'd0);
    step(2);
    rst_n = 1'b1;
    n0 = st_t.size();
    step(40);
    cmp("t1_no_strobe", 32'(st_t.size() - n0), 32'd0);
    cmp("t1_level_after", 32'(pif.level), 32'd0);
    cmp("no_dropped_emitted", 32'(seen_f), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
